pwm_breath_sequencer: RTL and testbench
=======================================

# pwm_breath_sequencer

Sequencer for the 8-LED PWM bank: owns a free-running PWM counter and schedules one "breath" (duty ramp up, hold, ramp down) per LED in turn, then advances to the next LED as a chaser. It replaces a fixed-duty PWM generator at the board top level, driving `led[7:0]` directly. It also exports channel/status signals for the debug header.

## Interface
- `CNT_W`, 8: PWM counter width. One PWM period is 2^CNT_W cycles.
- `STEP_DIV`, 4: PWM periods per ±1 duty step. Must be ≥1.
- `HOLD_PERIODS`, 16: PWM periods spent at peak duty. Must be ≥1.

Ports:
- `clk`, input, 1: single clock. All logic is on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `en`, input, 1: run request. Level-sensitive.
- `dir`, input, 1: chase direction. 0 = idx+1, 1 = idx−1, both mod 8. Sampled in NEXT.
- `duty_max`, input, CNT_W: peak duty. Sampled into `duty_lim` on entry to RISE.
- `led`, output, 8: registered PWM outputs.
- `active_idx`, output, 3: index of the LED currently breathing.
- `busy`, output, 1: high whenever state ≠ IDLE.
- `period_tick`, output, 1: one-cycle pulse on the last cycle of each PWM period.

## Operation
- `cnt` (CNT_W bits) increments every cycle and wraps 2^CNT_W−1 → 0. It runs in all states.
- `period_tick` = (cnt == 2^CNT_W−1).
- `step_tick` = `period_tick` AND (`step_cnt` == STEP_DIV−1).
  - `step_cnt` counts `period_tick`s in RISE/FALL only.
  - `step_cnt` clears on every state change.
- Per-cycle LED update: `led[i]` <= (i == active_idx) && (cnt < duty). All other bits <= 0.
  - Compare is unsigned, CNT_W bits.
  - duty = 0 gives fully off; duty = 2^CNT_W−1 gives high for all but one cycle per period.

FSM states: IDLE, RISE, HOLD, FALL, NEXT.
- IDLE: duty = 0. `active_idx` holds. Go to RISE when en = 1. On entry to RISE: `duty_lim` <= duty_max.
- RISE: on `step_tick`, duty <= duty+1. Go to HOLD on the cycle duty == duty_lim, checked before incrementing. If duty_lim = 0, go to HOLD at the first `step_tick` with duty unchanged.
- HOLD: count `period_tick`s. Go to FALL after HOLD_PERIODS of them.
- FALL: on `step_tick`, duty <= duty−1. Go to NEXT when duty == 0 (checked each cycle).
- NEXT: lasts one cycle. `active_idx` advances per `dir`, wrapping 7→0 or 0→7. Next state is RISE (re-sampling duty_max) if en = 1, else IDLE.
- en drop in RISE or HOLD: go to FALL on the next cycle. Duty ramps down from its current value, so there is no abrupt turn-off.
- en drop in FALL: no effect.
- Arithmetic: duty never exceeds duty_lim and never underflows below 0. There is no wrap in duty.
- Reset mid-operation: all state returns to reset values asynchronously. `led` goes low immediately.

## Timing
- Reset values: led = 0, active_idx = 0, busy = 0, period_tick = 0, cnt = 0, duty = 0, step_cnt = 0, state = IDLE.
- `led` has 1-cycle latency from `cnt`/`duty`.
- `busy` is registered from the state and rises the cycle after en is sampled high in IDLE.
- One full breath with duty_lim = D: approximately (2·D·STEP_DIV + HOLD_PERIODS) periods, plus alignment to the first `period_tick`, plus 1 NEXT cycle.
- `active_idx` changes exactly once per breath, on the NEXT→RISE/IDLE transition.
- A change of `duty_max` mid-breath has no effect until the next RISE entry.

## Configuration
- `PWM_TRAIL_EN` defined: the previous LED, (active_idx − step direction) mod 8, is driven at the fixed duty duty_lim>>2 using the same cnt compare. This trail applies in RISE, HOLD and FALL only and is forced off in IDLE. It resets to "no previous LED" (trail off) until the first NEXT.
- Not defined: only the `active_idx` LED is ever non-zero. No trail logic is synthesized.

## Test plan
Use CNT_W = 4, STEP_DIV = 1, HOLD_PERIODS = 2 unless noted.
- Reset check: assert rst mid-RISE → the same cycle, led = 0, busy = 0, active_idx = 0. After release with en = 0, everything stays 0 for ≥ 64 cycles.
- Single breath: en = 1, duty_max = 3, dir = 0. Per-period high counts on led[0] are 0,1,2,3 (×2 in HOLD),2,1,0. active_idx then becomes 1, and busy stays high.
- Wrap and direction: dir = 1 starting from active_idx = 0 → after one breath, active_idx = 7. With dir = 0 from 7 → 0.
- Graceful stop: drop en in HOLD at duty = 3 → state goes to FALL next cycle, duty ramps 2,1,0, then NEXT, then IDLE, with busy = 0 one cycle after NEXT.
- Edge duties: duty_max = 0 → led stays 0 and the breath still advances active_idx. duty_max = 15 → led high 15 of 16 cycles per period in HOLD.
- `PWM_TRAIL_EN` (when defined): second breath with duty_max = 8 → led[0] is high 2 cycles per period while led[1] breathes. Without the macro, led[0] stays 0.

Source files
------------

// File: rtl/pwm_breath_sequencer.sv
// Chasing "breath" PWM sequencer for an 8-LED bank: ramps one LED up, holds, ramps down, then moves on.
// Optional PWM_TRAIL_EN keeps the previously breathed LED glowing at a quarter of the peak duty.
module pwm_breath_sequencer #(
    parameter int CNT_W        = 8,
    parameter int STEP_DIV     = 4,
    parameter int HOLD_PERIODS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic [CNT_W-1:0] duty_max,
    output logic [7:0]       led,
    output logic [2:0]       active_idx,
    output logic             busy,
    output logic             period_tick
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RISE = 3'd1;
    localparam logic [2:0] S_HOLD = 3'd2;
    localparam logic [2:0] S_FALL = 3'd3;
    localparam logic [2:0] S_NEXT = 3'd4;

    localparam int STEP_W = $clog2(STEP_DIV + 1);
    localparam int HOLD_W = $clog2(HOLD_PERIODS + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = '1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_PERIODS - 1);

    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  duty;
    logic [CNT_W-1:0]  duty_nxt;
    logic [CNT_W-1:0]  duty_lim;
    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic [STEP_W-1:0] step_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              step_tick;
    logic [7:0]        led_nxt;

    function automatic logic [CNT_W-1:0] duty_inc_sat(input logic [CNT_W-1:0] d,
                                                      input logic [CNT_W-1:0] lim);
        return (d < lim) ? d + CNT_W'(1) : d;
    endfunction

    function automatic logic [CNT_W-1:0] duty_dec_sat(input logic [CNT_W-1:0] d);
        return (d != '0) ? d - CNT_W'(1) : '0;
    endfunction

    assign period_tick = (cnt == CNT_LAST);
    assign step_tick   = period_tick && (step_cnt == STEP_LAST);

    always_comb begin
        state_nxt = state;
        duty_nxt  = duty;
        case (state)
            S_IDLE: begin
                duty_nxt = '0;
                if (en) state_nxt = S_RISE;
            end
            S_RISE: begin
                // The peak test happens on the step boundary, so duty_lim = 0 still waits one step.
                if (!en) begin
                    state_nxt = S_FALL;
                end else if (step_tick) begin
                    if (duty == duty_lim) state_nxt = S_HOLD;
                    else                  duty_nxt  = duty_inc_sat(duty, duty_lim);
                end
            end
            S_HOLD: begin
                if (!en || (period_tick && hold_cnt == HOLD_LAST)) state_nxt = S_FALL;
            end
            S_FALL: begin
                if (duty == '0)     state_nxt = S_NEXT;
                else if (step_tick) duty_nxt  = duty_dec_sat(duty);
            end
            S_NEXT: begin
                state_nxt = en ? S_RISE : S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
                duty_nxt  = '0;
            end
        endcase
    end

`ifdef PWM_TRAIL_EN
    logic [2:0]       trail_idx;
    logic             trail_vld;
    logic             trail_on;
    logic [CNT_W-1:0] trail_duty;

    assign trail_on   = trail_vld && (state == S_RISE || state == S_HOLD || state == S_FALL);
    assign trail_duty = duty_lim >> 2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trail_idx <= 3'd0;
            trail_vld <= 1'b0;
        end else if (state == S_NEXT) begin
            trail_idx <= active_idx;
            trail_vld <= 1'b1;
        end
    end

    always_comb begin
        led_nxt = (cnt < duty) ? (8'b1 << active_idx) : 8'b0;
        if (trail_on && (cnt < trail_duty)) led_nxt = led_nxt | (8'b1 << trail_idx);
    end
`else
    always_comb begin
        led_nxt = (cnt < duty) ? (8'b1 << active_idx) : 8'b0;
    end
`endif

    // Control state: counters, FSM, LED register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            state      <= S_IDLE;
            duty       <= '0;
            step_cnt   <= '0;
            hold_cnt   <= '0;
            active_idx <= 3'd0;
            busy       <= 1'b0;
            led        <= 8'b0;
        end else begin
            cnt   <= cnt + CNT_W'(1);
            state <= state_nxt;
            duty  <= duty_nxt;
            busy  <= (state_nxt != S_IDLE);
            led   <= led_nxt;

            if (state_nxt != state)
                step_cnt <= '0;
            else if ((state == S_RISE || state == S_FALL) && period_tick)
                step_cnt <= step_tick ? '0 : step_cnt + STEP_W'(1);

            if (state_nxt != state)
                hold_cnt <= '0;
            else if (state == S_HOLD && period_tick)
                hold_cnt <= hold_cnt + HOLD_W'(1);

            if (state == S_NEXT)
                active_idx <= dir ? active_idx - 3'd1 : active_idx + 3'd1;
        end
    end

    // Peak duty is latched only when a breath starts
    always_ff @(posedge clk) begin
        if (state_nxt == S_RISE && state != S_RISE) duty_lim <= duty_max;
    end

endmodule

// File: tb/tb_pwm_breath_sequencer.sv
// Bench for pwm_breath_sequencer: per-period LED high counts are scored against a queue of expected
// windows; table of breaths plus hand sequences for stop, continuous chase and reset.
`timescale 1ns/1ps
module tb_pwm_breath_sequencer;

    localparam int CNT_W        = 4;
    localparam int STEP_DIV     = 1;
    localparam int HOLD_PERIODS = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en  = 1'b0;
    logic             dir = 1'b0;
    logic [CNT_W-1:0] duty_max = '0;
    logic [7:0]       led;
    logic [2:0]       active_idx;
    logic             busy;
    logic             period_tick;

    pwm_breath_sequencer #(
        .CNT_W(CNT_W), .STEP_DIV(STEP_DIV), .HOLD_PERIODS(HOLD_PERIODS)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .duty_max(duty_max),
        .led(led), .active_idx(active_idx), .busy(busy), .period_tick(period_tick)
    );

    always #5 clk = ~clk;

    typedef struct { int idx; int cnt; int oth; } win_t;
    typedef struct { bit d; int dmax; int exp_idx; } vec_t;

    win_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_on = 0, mon_skip = 0, prev_tick = 0, had_next = 0;
    int   acc = 0, acc_oth = 0, cur_idx = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    // One window = the 16 led samples belonging to one PWM period (led lags cnt by a cycle).
    always begin : mon
        win_t w;
        @(posedge clk);
        #1;
        if (mon_on) begin
            if (mon_skip) begin
                mon_skip = 0;
            end else begin
                acc     += int'(led[sb_q[0].idx]);
                acc_oth += $countones(led) - int'(led[sb_q[0].idx]);
                if (prev_tick) begin
                    w = sb_q.pop_front();
                    chk("win_led", acc, w.cnt);
                    chk("win_other", acc_oth, w.oth);
                    acc = 0;
                    acc_oth = 0;
                    if (sb_q.size() == 0) mon_on = 0;
                end
            end
        end
        prev_tick = period_tick;
    end

    function automatic int trail_of(input int d);
        int tr;
        tr = 0;
`ifdef PWM_TRAIL_EN
        if (had_next) tr = d >> 2;
`endif
        return tr;
    endfunction

    task automatic push_win(input int idx, input int c, input int oth);
        win_t w;
        w.idx = idx; w.cnt = c; w.oth = oth;
        sb_q.push_back(w);
    endtask

    task automatic push_breath(input int idx, input int d);
        int tr;
        tr = trail_of(d);
        for (int k = 0; k <= d; k++) push_win(idx, k, tr);
        push_win(idx, d, tr);
        push_win(idx, d, tr);
        for (int k = d; k >= 1; k--) push_win(idx, k, tr);
        push_win(idx, 0, (tr > 0) ? 1 : 0);
    endtask

    task automatic arm();
        acc = 0; acc_oth = 0; mon_skip = 1; mon_on = 1;
    endtask

    task automatic sync_period();
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (!period_tick && n < 64);
        chk("sync_tick", int'(period_tick), 1);
    endtask

    task automatic wait_q(input int sz, input int budget);
        int n;
        n = 0;
        while (sb_q.size() > sz && n < budget) begin @(negedge clk); n++; end
        chk("q_progress", (sb_q.size() > sz) ? 0 : 1, 1);
    endtask

    task automatic wait_mon_done(input int budget);
        int n;
        n = 0;
        while (mon_on && n < budget) begin @(negedge clk); n++; end
        chk("mon_done", int'(mon_on), 0);
        mon_on = 0;
        sb_q.delete();
    endtask

    task automatic run_breath(input bit d, input int dmax, input int exp_idx);
        sync_period();
        dir = d; duty_max = CNT_W'(dmax); en = 1'b1;
        push_breath(cur_idx, dmax);
        arm();
        @(negedge clk);
        chk("busy_rise", int'(busy), 1);
        duty_max = ~CNT_W'(dmax);
        wait_q(dmax + 1, 1200);
        en = 1'b0;
        wait_mon_done(600);
        chk("idx_next", int'(active_idx), exp_idx);
        chk("busy_idle", int'(busy), 0);
        cur_idx = exp_idx;
        had_next = 1;
    endtask

    initial begin
        vec_t vecs[6];
        int   n, bad, pb;
        vecs[0] = '{d: 1'b0, dmax: 3,  exp_idx: 1};
        vecs[1] = '{d: 1'b1, dmax: 2,  exp_idx: 0};
        vecs[2] = '{d: 1'b1, dmax: 0,  exp_idx: 7};
        vecs[3] = '{d: 1'b0, dmax: 1,  exp_idx: 0};
        vecs[4] = '{d: 1'b0, dmax: 15, exp_idx: 1};
        vecs[5] = '{d: 1'b0, dmax: 8,  exp_idx: 2};

        repeat (3) @(negedge clk);
        chk("reset_led", int'(led), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_idx", int'(active_idx), 0);
        chk("reset_tick", int'(period_tick), 0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_breath(vecs[i].d, vecs[i].dmax, vecs[i].exp_idx);

        // Graceful stop: drop en at the start of the first HOLD period (duty 3)
        sync_period();
        dir = 1'b0; duty_max = CNT_W'(3); en = 1'b1;
        for (int k = 0; k <= 3; k++) push_win(cur_idx, k, trail_of(3));
        for (int k = 3; k >= 1; k--) push_win(cur_idx, k, trail_of(3));
        push_win(cur_idx, 0, (trail_of(3) > 0) ? 1 : 0);
        arm();
        wait_q(4, 200);
        en = 1'b0;
        n = 0; pb = int'(busy);
        while (active_idx == 3'd2 && n < 300) begin pb = int'(busy); @(negedge clk); n++; end
        chk("stop_idx", int'(active_idx), 3);
        chk("stop_busy_next", pb, 1);
        chk("stop_busy_idle", int'(busy), 0);
        wait_mon_done(300);
        cur_idx = 3;

        // Continuous chase: en held high keeps busy up across NEXT
        dir = 1'b1; duty_max = '0; en = 1'b1;
        n = 0;
        while (active_idx == 3'd3 && n < 400) begin @(negedge clk); n++; end
        chk("cont_idx", int'(active_idx), 2);
        chk("cont_busy", int'(busy), 1);
        @(negedge clk);
        chk("cont_busy2", int'(busy), 1);
        en = 1'b0;
        n = 0;
        while (busy && n < 400) begin @(negedge clk); n++; end
        chk("cont_stop_idx", int'(active_idx), 1);
        chk("cont_stop_busy", int'(busy), 0);
        cur_idx = 1;

        // Asynchronous reset in the middle of a rise
        sync_period();
        dir = 1'b0; duty_max = CNT_W'(3); en = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (led == 8'b0 && n < 100);
        chk("pre_rst_led", (led != 8'b0) ? 1 : 0, 1);
        #2 rst = 1'b1;
        #1;
        chk("rst_led", int'(led), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_idx", int'(active_idx), 0);
        chk("rst_tick", int'(period_tick), 0);
        en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (led != 8'b0 || busy || active_idx != 3'd0) bad++;
        end
        chk("quiet_after_rst", bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
